// File: rtl/movimiento_pkg.sv
// Move codes shared by the button front end and the downstream control stage,
// plus the fixed-priority encoder that turns a button vector into a move.
package movimiento_pkg;

    typedef enum logic [2:0] {
        NINGUNO   = 3'd0,
        IZQUIERDA = 3'd1,
        DERECHA   = 3'd2,
        ARRIBA    = 3'd3,
        ABAJO     = 3'd4
    } mov_t;

    // Button vector bit order: [0] left, [1] right, [2] up, [3] down
    localparam int unsigned NUM_BTN = 4;

    function automatic mov_t codificar(input logic [NUM_BTN-1:0] v);
        if (v[0]) return IZQUIERDA;
        if (v[1]) return DERECHA;
        if (v[2]) return ARRIBA;
        if (v[3]) return ABAJO;
        return NINGUNO;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
module sincronizador #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/entrada_movimiento.sv
// Debounces four direction buttons and emits exactly one move code per press
// over a valid/ready handshake.
module entrada_movimiento
    import movimiento_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arr,
    input  logic       btn_aba,
    input  logic       mov_ready,
    output logic [2:0] movimiento,
    output logic       mov_valid
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDebounce, StEmit, StWaitRelease} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_BTN-1:0] cand_q, cand_d;
    mov_t               mov_q, mov_d;
    logic               valid_q, valid_d;
    logic [NUM_BTN-1:0] vec;

    sincronizador #(
        .Width(NUM_BTN)
    ) u_sinc (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({btn_aba, btn_arr, btn_der, btn_izq}),
        .q    (vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= '0;
            mov_q   <= NINGUNO;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            mov_q   <= mov_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        mov_d   = mov_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (vec != '0) begin
                    cand_d  = vec;
                    cnt_d   = '0;
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (vec == '0) begin
                    state_d = StIdle;
                end else if (vec != cand_q) begin
                    // Bounce into a different combination restarts the window
                    cand_d = vec;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StEmit;
                    mov_d   = codificar(cand_q);
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StEmit: begin
                if (mov_ready) begin
                    state_d = StWaitRelease;
                    cnt_d   = '0;
                    mov_d   = NINGUNO;
                    valid_d = 1'b0;
                end
            end
            StWaitRelease: begin
                // Release must be stable for a full window before a new press counts
                if (vec != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign movimiento = mov_q;
    assign mov_valid  = valid_q;

endmodule

// File: tb/tb_entrada_movimiento.sv
// Directed bench: stimulus queues expected moves; a negedge monitor checks them.
module tb_entrada_movimiento;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_izq, btn_der, btn_arr, btn_aba;
    logic       mov_ready;
    logic [2:0] movimiento;
    logic       mov_valid;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    bit         prev_valid = 1'b0;
    bit         prev_ready = 1'b0;
    logic [2:0] prev_mov = 3'd0;

    entrada_movimiento #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_izq   (btn_izq),
        .btn_der   (btn_der),
        .btn_arr   (btn_arr),
        .btn_aba   (btn_aba),
        .mov_ready (mov_ready),
        .movimiento(movimiento),
        .mov_valid (mov_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_move(input logic [2:0] code);
        exp_t e;
        e.code = code;
        e.cyc  = cyc + 7;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk(mov_valid == 1'b1, "hold_valid", int'(mov_valid), 1);
                chk(movimiento == prev_mov, "hold_code", int'(movimiento), int'(prev_mov));
            end else if (prev_valid) begin
                chk(mov_valid == 1'b0, "drop_after_handshake", int'(mov_valid), 0);
            end else if (mov_valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_move", int'(movimiento), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(movimiento == e.code, "move_code", int'(movimiento), int'(e.code));
                    chk(cyc == e.cyc, "move_cycle", cyc, e.cyc);
                end
            end
            if (!mov_valid) chk(movimiento == 3'd0, "idle_code", int'(movimiento), 0);
            prev_valid = mov_valid;
            prev_ready = mov_ready;
            prev_mov   = movimiento;
        end
    end

    initial begin
        rst_n = 1'b0;
        {btn_izq, btn_der, btn_arr, btn_aba} = 4'b0;
        mov_ready = 1'b1;
        tick(3);
        chk(mov_valid == 1'b0, "reset_valid", int'(mov_valid), 0);
        chk(movimiento == 3'd0, "reset_code", int'(movimiento), 0);
        rst_n = 1'b1;
        tick(2);

        // Steady right press: one move, none while held
        btn_der = 1'b1;
        expect_move(3'd2);
        tick(20);
        btn_der = 1'b0;
        tick(10);

        // Bouncing up press
        btn_arr = 1'b1;
        tick(1);
        btn_arr = 1'b0;
        tick(1);
        btn_arr = 1'b1;
        expect_move(3'd3);
        tick(15);
        btn_arr = 1'b0;
        tick(10);

        // Simultaneous left + down resolves to left
        btn_izq = 1'b1;
        btn_aba = 1'b1;
        expect_move(3'd1);
        tick(12);
        btn_izq = 1'b0;
        btn_aba = 1'b0;
        tick(10);

        // Down with back-pressure for 10 valid cycles
        mov_ready = 1'b0;
        btn_aba = 1'b1;
        expect_move(3'd4);
        tick(17);
        mov_ready = 1'b1;
        tick(3);
        btn_aba = 1'b0;
        tick(10);

        // Short release ignored, long release re-arms
        btn_der = 1'b1;
        expect_move(3'd2);
        tick(12);
        btn_der = 1'b0;
        tick(2);
        btn_der = 1'b1;
        tick(12);
        btn_der = 1'b0;
        tick(6);
        btn_der = 1'b1;
        expect_move(3'd2);
        tick(15);
        btn_der = 1'b0;
        tick(10);

        // Reset during EMIT, button kept held
        btn_der = 1'b1;
        expect_move(3'd2);
        tick(7);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(mov_valid == 1'b0, "reset_emit_valid", int'(mov_valid), 0);
        chk(movimiento == 3'd0, "reset_emit_code", int'(movimiento), 0);
        tick(2);
        rst_n = 1'b1;
        expect_move(3'd2);
        tick(12);
        btn_der = 1'b0;
        tick(12);

        chk(sb.size() == 0, "moves_outstanding", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
